// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - multi-read-port register file with load scoreboard; optional RF_BYPASS_EN forwarding
module reg_file_sb #(
    parameter int N      = 32,
    parameter int ADDR   = 5,
    parameter int RPORTS = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     Reg_Write_i,
    input  logic [ADDR-1:0]          Write_Register_i,
    input  logic [N-1:0]             Write_Data_i,
    input  logic                     Ld_Write_i,
    input  logic [ADDR-1:0]          Ld_Register_i,
    input  logic [N-1:0]             Ld_Data_i,
    input  logic                     Ld_Issue_i,
    input  logic [ADDR-1:0]          Ld_Issue_Register_i,
    input  logic [RPORTS*ADDR-1:0]   Read_Register_i,
    output logic [RPORTS*N-1:0]      Read_Data_o,
    output logic [RPORTS-1:0]        Read_Busy_o,
    output logic [ADDR:0]            Pending_Count_o
);
    localparam int DEPTH = 1 << ADDR;

    logic [N-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;
    logic [ADDR:0]    count_next;
    logic [ADDR-1:0]  ra;
    logic [N-1:0]     rd;
    logic             busy;
    logic             alu_we;
    logic             ld_we;

    assign ld_we  = Ld_Write_i && (Ld_Register_i != '0);
    assign alu_we = Reg_Write_i && (Write_Register_i != '0)
                    && !(ld_we && (Ld_Register_i == Write_Register_i));

    // Issue is applied after writeback clear so a same-address issue keeps the bit set
    always_comb begin
        pending_next = pending;
        count_next   = '0;
        if (Ld_Write_i)
            pending_next[Ld_Register_i] = 1'b0;
        if (Ld_Issue_i && (Ld_Issue_Register_i != '0))
            pending_next[Ld_Issue_Register_i] = 1'b1;
        pending_next[0] = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            count_next = count_next + (ADDR+1)'(pending_next[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            pending         <= '0;
            Pending_Count_o <= '0;
        end else begin
            if (alu_we)
                regs[Write_Register_i] <= Write_Data_i;
            if (ld_we)
                regs[Ld_Register_i] <= Ld_Data_i;
            pending         <= pending_next;
            Pending_Count_o <= count_next;
        end
    end

    always_comb begin
        Read_Data_o = '0;
        Read_Busy_o = '0;
        ra          = '0;
        rd          = '0;
        busy        = 1'b0;
        for (int k = 0; k < RPORTS; k++) begin
            ra   = Read_Register_i[k*ADDR +: ADDR];
            rd   = (ra == '0) ? '0 : regs[ra];
            busy = pending[ra];
`ifdef RF_BYPASS_EN
            if (ra != '0) begin
                if (Ld_Write_i && (Ld_Register_i == ra))
                    rd = Ld_Data_i;
                else if (Reg_Write_i && (Write_Register_i == ra))
                    rd = Write_Data_i;
            end
            if (Ld_Write_i && (Ld_Register_i == ra)
                && !(Ld_Issue_i && (Ld_Issue_Register_i == ra)))
                busy = 1'b0;
`endif
            if (reset) begin
                Read_Data_o[k*N +: N] = rd;
                Read_Busy_o[k]        = busy;
            end
        end
    end
endmodule
